// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, FSM state encoding and control-field encodings for the multicycle controller.
// MULTICYCLE_JAL_EN adds the JALEX state (code 12).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11
`ifdef MULTICYCLE_JAL_EN
    ,S_JALEX = 4'd12
`endif
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/memory-ready inputs and datapath control outputs of the multicycle controller.
interface multicycle_control_if;

  logic [5:0] Opcode;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal;
  logic       retire;

  modport master (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
    input  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, illegal, retire
  );

  modport slave (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
    output RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, illegal, retire
  );

endinterface

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - maps FSM state and mem_ready to the control word; reset forces every output low.
// MULTICYCLE_JAL_EN enables the JALEX decode.
module mc_output_decode
  import mips_pkg::*;
(
  input  logic   i_reset,
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_illegal_op,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    if (!i_reset) begin
      case (i_state)
        S_FETCH: begin
          o_ctrl.MemRead = 1'b1;
          o_ctrl.ALUSrcB = ALUSRCB_FOUR;
          o_ctrl.IRWrite = i_mem_ready;
          o_ctrl.PCWrite = i_mem_ready;
        end
        S_DECODE: begin
          o_ctrl.ALUSrcB = ALUSRCB_BRANCH;
          o_ctrl.illegal = i_illegal_op;
        end
        S_MEMADR: begin
          o_ctrl.ALUSrcA = 1'b1;
          o_ctrl.ALUSrcB = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          o_ctrl.IorD    = 1'b1;
          o_ctrl.MemRead = 1'b1;
        end
        S_MEMWB: begin
          o_ctrl.MemtoReg = MEMTOREG_MEM;
          o_ctrl.RegWrite = 1'b1;
          o_ctrl.retire   = 1'b1;
        end
        S_MEMWR: begin
          o_ctrl.IorD     = 1'b1;
          o_ctrl.MemWrite = 1'b1;
          o_ctrl.retire   = i_mem_ready;
        end
        S_RTEX: begin
          o_ctrl.ALUSrcA = 1'b1;
          o_ctrl.ALUOp   = ALUOP_FUNCT;
        end
        S_RTWB: begin
          o_ctrl.RegDst   = REGDST_RD;
          o_ctrl.RegWrite = 1'b1;
          o_ctrl.retire   = 1'b1;
        end
        S_BEQEX: begin
          o_ctrl.ALUSrcA     = 1'b1;
          o_ctrl.ALUOp       = ALUOP_SUB;
          o_ctrl.PCWriteCond = 1'b1;
          o_ctrl.PCSource    = PCSRC_ALUOUT;
          o_ctrl.retire      = 1'b1;
        end
        S_ADDIEX: begin
          o_ctrl.ALUSrcA = 1'b1;
          o_ctrl.ALUSrcB = ALUSRCB_IMM;
        end
        S_ADDIWB: begin
          o_ctrl.RegWrite = 1'b1;
          o_ctrl.retire   = 1'b1;
        end
        S_JEX: begin
          o_ctrl.PCWrite  = 1'b1;
          o_ctrl.PCSource = PCSRC_JUMP;
          o_ctrl.retire   = 1'b1;
        end
`ifdef MULTICYCLE_JAL_EN
        S_JALEX: begin
          o_ctrl.PCWrite  = 1'b1;
          o_ctrl.PCSource = PCSRC_JUMP;
          o_ctrl.RegDst   = REGDST_RA;
          o_ctrl.MemtoReg = MEMTOREG_PC;
          o_ctrl.RegWrite = 1'b1;
          o_ctrl.retire   = 1'b1;
        end
`endif
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM: state register and next-state logic.
// MULTICYCLE_JAL_EN makes opcode 000011 (jal) legal via JALEX.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  state_t r_state;
  state_t w_next;
  logic   w_illegal_op;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    w_illegal_op = 1'b0;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:     w_next = S_RTEX;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       w_next = S_JALEX;
`endif
          default: begin
            w_next       = S_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      // Only lw and sw reach MEMADR, so anything that is not lw is treated as sw.
      S_MEMADR: w_next = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTEX:   w_next = S_RTWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .i_reset      (reset),
    .i_state      (r_state),
    .i_mem_ready  (bus.mem_ready),
    .i_illegal_op (w_illegal_op),
    .o_ctrl       (w_ctrl)
  );

  assign bus.PCWrite     = w_ctrl.PCWrite;
  assign bus.PCWriteCond = w_ctrl.PCWriteCond;
  assign bus.IorD        = w_ctrl.IorD;
  assign bus.MemRead     = w_ctrl.MemRead;
  assign bus.MemWrite    = w_ctrl.MemWrite;
  assign bus.IRWrite     = w_ctrl.IRWrite;
  assign bus.ALUSrcA     = w_ctrl.ALUSrcA;
  assign bus.RegWrite    = w_ctrl.RegWrite;
  assign bus.RegDst      = w_ctrl.RegDst;
  assign bus.MemtoReg    = w_ctrl.MemtoReg;
  assign bus.ALUSrcB     = w_ctrl.ALUSrcB;
  assign bus.ALUOp       = w_ctrl.ALUOp;
  assign bus.PCSource    = w_ctrl.PCSource;
  assign bus.illegal     = w_ctrl.illegal;
  assign bus.retire      = w_ctrl.retire;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench: per-instruction phase tables predict every cycle's control word.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
    logic       retire;
  } word_t;

  typedef struct {
    string name;
    word_t base;
    word_t on_ready;
    bit    waits;
    bit    op_sens;
  } phase_t;

  phase_t ph[$];
  word_t  exp_q[$];
  string  tag_q[$];
  int     checks   = 0;
  int     failures = 0;
  word_t  mon_exp;
  word_t  mon_got;
  string  mon_tag;

  function automatic word_t observed();
    word_t w;
    w.PCWrite     = bus.PCWrite;
    w.PCWriteCond = bus.PCWriteCond;
    w.IorD        = bus.IorD;
    w.MemRead     = bus.MemRead;
    w.MemWrite    = bus.MemWrite;
    w.IRWrite     = bus.IRWrite;
    w.ALUSrcA     = bus.ALUSrcA;
    w.RegWrite    = bus.RegWrite;
    w.RegDst      = bus.RegDst;
    w.MemtoReg    = bus.MemtoReg;
    w.ALUSrcB     = bus.ALUSrcB;
    w.ALUOp       = bus.ALUOp;
    w.PCSource    = bus.PCSource;
    w.illegal     = bus.illegal;
    w.retire      = bus.retire;
    return w;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_got = observed();
      checks++;
      if (mon_got !== mon_exp) begin
        failures++;
        $display("FAIL %s got=%05h expected=%05h", mon_tag, mon_got, mon_exp);
      end
    end
  end

  function automatic bit legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MULTICYCLE_JAL_EN
      6'b000011: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic add_phase(input string n, input word_t b, input word_t r, input bit w, input bit s);
    phase_t p;
    p.name = n; p.base = b; p.on_ready = r; p.waits = w; p.op_sens = s;
    ph.push_back(p);
  endtask

  // Each instruction is a list of cycles; waiting cycles repeat until mem_ready.
  task automatic build(input logic [5:0] op);
    word_t b, r, z;
    z = '0;
    ph.delete();
    b = '0; b.MemRead = 1; b.ALUSrcB = 2'b01;
    r = '0; r.IRWrite = 1; r.PCWrite = 1;
    add_phase("fetch", b, r, 1, 0);
    b = '0; b.ALUSrcB = 2'b11; b.illegal = !legal(op);
    add_phase("decode", b, z, 0, 1);
    if (!legal(op)) return;
    case (op)
      6'b000000: begin
        b = '0; b.ALUSrcA = 1; b.ALUOp = 2'b10; add_phase("rtex", b, z, 0, 0);
        b = '0; b.RegDst = 2'b01; b.RegWrite = 1; b.retire = 1; add_phase("rtwb", b, z, 0, 0);
      end
      6'b100011, 6'b101011: begin
        b = '0; b.ALUSrcA = 1; b.ALUSrcB = 2'b10; add_phase("memadr", b, z, 0, 1);
        if (op == 6'b100011) begin
          b = '0; b.IorD = 1; b.MemRead = 1; add_phase("memrd", b, z, 1, 0);
          b = '0; b.MemtoReg = 2'b01; b.RegWrite = 1; b.retire = 1; add_phase("memwb", b, z, 0, 0);
        end else begin
          b = '0; b.IorD = 1; b.MemWrite = 1;
          r = '0; r.retire = 1;
          add_phase("memwr", b, r, 1, 0);
        end
      end
      6'b000100: begin
        b = '0; b.ALUSrcA = 1; b.ALUOp = 2'b01; b.PCWriteCond = 1; b.PCSource = 2'b01; b.retire = 1;
        add_phase("beqex", b, z, 0, 0);
      end
      6'b001000: begin
        b = '0; b.ALUSrcA = 1; b.ALUSrcB = 2'b10; add_phase("addiex", b, z, 0, 0);
        b = '0; b.RegWrite = 1; b.retire = 1; add_phase("addiwb", b, z, 0, 0);
      end
      6'b000010: begin
        b = '0; b.PCWrite = 1; b.PCSource = 2'b10; b.retire = 1; add_phase("jex", b, z, 0, 0);
      end
      default: begin
        b = '0; b.PCWrite = 1; b.PCSource = 2'b10; b.RegDst = 2'b10; b.MemtoReg = 2'b10;
        b.RegWrite = 1; b.retire = 1;
        add_phase("jalex", b, z, 0, 0);
      end
    endcase
  endtask

  task automatic cycle(input logic r, input logic [5:0] o, input logic m, input word_t e, input string t);
    reset         = r;
    bus.Opcode    = o;
    bus.mem_ready = m;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // rst_at: phase index whose ready cycle is replaced by a reset cycle (-1 = none); stall < 0 = random.
  task automatic run_instr(input logic [5:0] op, input int rst_at, input int stall);
    build(op);
    for (int i = 0; i < ph.size(); i++) begin
      int stalls;
      stalls = ph[i].waits ? ((stall < 0) ? int'($urandom_range(0, 3)) : stall) : 0;
      for (int c = 0; c <= stalls; c++) begin
        logic       rdy;
        logic [5:0] o;
        word_t      e;
        rdy = (c == stalls);
        if (!ph[i].waits) rdy = 1'($urandom_range(0, 1));
        o = ph[i].op_sens ? op : 6'($urandom);
        if (i == rst_at && c == stalls) begin
          cycle(1'b1, o, 1'b1, '0, $sformatf("op=%b reset_in_%s", op, ph[i].name));
          return;
        end
        e = rdy ? (ph[i].base | ph[i].on_ready) : ph[i].base;
        cycle(1'b0, o, rdy, e, $sformatf("op=%b %s c%0d rdy=%0b", op, ph[i].name, c, rdy));
      end
    end
  endtask

  initial begin
    logic [5:0] pool [7];
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};
    reset         = 1'b1;
    bus.Opcode    = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 6'b000000, 1'b0, '0, "reset_idle");
    cycle(1'b1, 6'b111111, 1'b1, '0, "reset_mem_ready");

    run_instr(6'b000000, -1, 0);
    run_instr(6'b100011, -1, 3);
    run_instr(6'b000100, -1, 0);
    run_instr(6'b111111, -1, 0);
    run_instr(6'b101011,  3, 0);
    run_instr(6'b000011, -1, 0);
    run_instr(6'b000010, -1, 0);
    run_instr(6'b001000, -1, 1);
    run_instr(6'b101011, -1, 2);
    run_instr(6'b100011,  3, 2);
    run_instr(6'b000000,  1, 0);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int         ra;
      int         sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 7) ? pool[sel] : 6'($urandom);
      ra  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, ra, -1);
    end

    reset = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, rising edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high.
REQ-003 SHALL provide: Opcode  input  6  instruction opcode from the instruction register.
REQ-004 SHALL provide: mem_ready  input  1  memory completes the current access this cycle.
REQ-005 SHALL provide outputs, all 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite.
REQ-006 SHALL provide outputs, all 2 bits: RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource.
REQ-007 SHALL provide: illegal  output  1  one-cycle pulse, unsupported opcode; retire  output  1  one-cycle pulse, instruction completed.

Function
REQ-008 SHALL be a Moore FSM; the only exception is qualification of writes by mem_ready in memory states.
REQ-009 SHALL encode states in 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, JALEX=12.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 FETCH SHALL drive MemRead=1, ALUSrcB=01; IRWrite=PCWrite=mem_ready; hold in FETCH while mem_ready=0, else go to DECODE.
REQ-012 DECODE SHALL drive ALUSrcB=11. Next state by Opcode: 000000->RTEX; 100011/101011->MEMADR; 000100->BEQEX; 001000->ADDIEX; 000010->JEX; 000011->JALEX; any other->FETCH with illegal=1.
REQ-013 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10; lw->MEMRD, sw->MEMWR.
REQ-014 MEMRD SHALL drive IorD=1, MemRead=1; hold until mem_ready=1, then go to MEMWB.
REQ-015 MEMWB SHALL drive MemtoReg=01, RegWrite=1, retire=1; then go to FETCH.
REQ-016 MEMWR SHALL drive IorD=1, MemWrite=1; hold until mem_ready=1, then go to FETCH with retire=1 in that cycle.
REQ-017 RTEX SHALL drive ALUSrcA=1, ALUOp=10, then go to RTWB. RTWB SHALL drive RegDst=01, RegWrite=1, retire=1, then go to FETCH.
REQ-018 BEQEX SHALL drive ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, retire=1, then go to FETCH.
REQ-019 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, then go to ADDIWB. ADDIWB SHALL drive RegWrite=1, retire=1, then go to FETCH.
REQ-020 JEX SHALL drive PCWrite=1, PCSource=10, retire=1, then go to FETCH.
REQ-021 JALEX SHALL drive PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1, retire=1, then go to FETCH.
REQ-022 SHALL give these CPI at mem_ready=1: R=4, lw=5, sw=4, beq=3, addi=4, j=3, jal=3.
REQ-023 SHALL ignore Opcode outside DECODE and MEMADR.
REQ-024 Unreachable state codes 13-15 SHALL go to FETCH with all outputs 0.

Reset
REQ-025 reset=1 at a clock edge SHALL force the state to FETCH, from any state including mid-wait on mem_ready.
REQ-026 While reset=1, all outputs SHALL be 0, including IRWrite/PCWrite with mem_ready=1.
REQ-027 The first cycle after reset is released SHALL be FETCH.

Configuration
REQ-028 Macro MULTICYCLE_JAL_EN defined: JALEX exists and opcode 000011 is legal.
REQ-029 Macro MULTICYCLE_JAL_EN undefined: JALEX is absent, 000011 goes to FETCH with illegal=1, and RegDst/MemtoReg never take value 10.

Structure
REQ-030 Shared package mips_pkg SHALL hold the opcode constants, the state typedef/encodings, and the ALUOp/PCSource/ALUSrcB encodings.
REQ-031 Sub-module mc_output_decode SHALL map state plus mem_ready to the control outputs; the top holds only the state register and next-state logic.

Verification
REQ-032 Reset, then Opcode=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=01 only in RTWB; retire pulses once.
REQ-033 lw with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, IorD=1 throughout; MemWB then writes with MemtoReg=01.
REQ-034 Opcode=000100 -> BEQEX in cycle 3 with PCWriteCond=1, PCSource=01, ALUOp=01.
REQ-035 Opcode=111111 -> illegal=1 in DECODE, FETCH next, no RegWrite/MemWrite.
REQ-036 reset asserted in MEMWR with mem_ready=1 -> MemWrite=0 that cycle; FETCH follows.
REQ-037 jal with and without MULTICYCLE_JAL_EN -> RegDst=10, MemtoReg=10, RegWrite=1 with it; illegal=1 without it.
